// File: rtl/psram_port_arbiter.sv
// Request front-end for the PSRAM controller: arbitrates cartridge byte reads
// against loader word writes, with a one-word read cache and a transaction timeout.
module psram_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CACHE_EN    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic [22:0] rd_addr,
    output logic        rd_ack,
    output logic [7:0]  rd_byte,
    input  logic        ld_req,
    input  logic [21:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ack,
    output logic        mem_cmd_en,
    output logic        mem_cmd_write,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wr_data,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_data_valid,
    input  logic        mem_busy,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;

    state_t           state, state_next;
    logic             op_load, fair, cache_valid, byte_sel, got_data;
    logic [21:0]      cache_tag;
    logic [15:0]      cache_data;
    logic [CNT_W-1:0] tmo_cnt;
    logic             grant, grant_ld, hit, tmo;
    logic [15:0]      rd_word;

    // Big-endian: even byte address is the high half of the word.
    function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic lo);
        return lo ? w[7:0] : w[15:8];
    endfunction

    always_comb begin
        grant      = !mem_busy && (rd_req || ld_req);
        grant_ld   = ld_req && (!rd_req || fair);
        hit        = (CACHE_EN != 0) && cache_valid && (cache_tag == rd_addr[22:1]);
        tmo        = (tmo_cnt == CNT_W'(TIMEOUT_CYC));
        rd_word    = mem_data_valid ? mem_rd_data : cache_data;
        state_next = state;
        case (state)
            IDLE:       if (grant) state_next = (!grant_ld && hit) ? RESP : ISSUE;
            ISSUE:      state_next = WAIT_START;
            WAIT_START: if (tmo) state_next = RESP;
                        else if (mem_busy) state_next = WAIT_DONE;
            WAIT_DONE:  if (tmo || !mem_busy) state_next = RESP;
            RESP:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    assign mem_cmd_en = (state == ISSUE);
    assign rd_ack     = (state == RESP) && !op_load;
    assign ld_ack     = (state == RESP) && op_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_load       <= 1'b0;
            fair          <= 1'b0;
            cache_valid   <= 1'b0;
            byte_sel      <= 1'b0;
            got_data      <= 1'b0;
            cache_tag     <= '0;
            cache_data    <= '0;
            tmo_cnt       <= '0;
            rd_byte       <= 8'h00;
            mem_cmd_write <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    op_load  <= grant_ld;
                    got_data <= 1'b0;
                    if (grant_ld) begin
                        fair          <= 1'b0;
                        mem_addr      <= ld_addr;
                        mem_cmd_write <= 1'b1;
                        mem_wr_data   <= ld_data;
                    end else begin
                        if (ld_req) fair <= 1'b1;
                        byte_sel <= rd_addr[0];
                        if (hit) begin
                            rd_byte <= pick_byte(cache_data, rd_addr[0]);
                        end else begin
                            mem_addr      <= rd_addr[22:1];
                            mem_cmd_write <= 1'b0;
                            mem_wr_data   <= ld_data;
                        end
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT_START, WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo) begin
                        timeout_err <= 1'b1;
                        cache_valid <= 1'b0;
                        if (!op_load) rd_byte <= 8'hFF;
                    end else if (state == WAIT_DONE) begin
                        if (mem_data_valid && !op_load) begin
                            cache_data <= mem_rd_data;
                            got_data   <= 1'b1;
                        end
                        // Data may arrive in the same cycle busy falls, so use rd_word.
                        if (!mem_busy) begin
                            if (op_load) begin
                                if (cache_tag == mem_addr) cache_data <= mem_wr_data;
                            end else if (got_data || mem_data_valid) begin
                                cache_valid <= 1'b1;
                                cache_tag   <= mem_addr;
                                rd_byte     <= pick_byte(rd_word, byte_sel);
                            end else begin
                                cache_valid <= 1'b0;
                                rd_byte     <= 8'hFF;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Randomized self-checking bench for psram_port_arbiter with a behavioural
// PSRAM controller and a word-memory / one-entry-cache reference model.
module tb_psram_port_arbiter;

    localparam int unsigned TMO = 16;
    localparam int unsigned PER = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [22:0] rd_addr = '0;
    logic        rd_ack;
    logic [7:0]  rd_byte;
    logic        ld_req = 1'b0;
    logic [21:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_ack;
    logic        mem_cmd_en;
    logic        mem_cmd_write;
    logic [21:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data = '0;
    logic        mem_data_valid = 1'b0;
    logic        mem_busy = 1'b0;
    logic        timeout_err;

    psram_port_arbiter #(.TIMEOUT_CYC(TMO), .CACHE_EN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_byte(rd_byte),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_write(mem_cmd_write), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_data_valid(mem_data_valid), .mem_busy(mem_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] default_word(input logic [21:0] a);
        return (a[15:0] * 16'd37) ^ 16'h5AC3;
    endfunction

    // External controller: busy one cycle after cmd_en, data one cycle before busy falls.
    logic [15:0] ctl_mem [int unsigned];
    bit          stall = 0, ctl_kill = 0, ctl_active = 0;
    int          ctl_t, ctl_lat;
    logic        ctl_write;
    logic [21:0] ctl_addr;
    logic [15:0] ctl_wdata;
    int          cmd_cnt = 0;
    logic        last_write;
    logic [21:0] last_addr;
    logic [15:0] last_wdata;
    time         issue_time, busy_fall_time;
    int          ack_q[$];

    always @(negedge clk) begin
        if (mem_cmd_en) begin
            cmd_cnt++;
            last_write = mem_cmd_write;
            last_addr  = mem_addr;
            last_wdata = mem_wr_data;
            issue_time = $time;
        end
        if (rd_ack) ack_q.push_back(0);
        if (ld_ack) ack_q.push_back(1);
        mem_data_valid = 1'b0;
        if (ctl_kill) begin
            ctl_active = 0;
            mem_busy   = 1'b0;
        end else if (!ctl_active) begin
            if (mem_cmd_en) begin
                ctl_active = 1;
                ctl_t      = 0;
                ctl_write  = mem_cmd_write;
                ctl_addr   = mem_addr;
                ctl_wdata  = mem_wr_data;
                ctl_lat    = $urandom_range(3, 8);
            end
        end else begin
            ctl_t++;
            if (ctl_t == 1) mem_busy = 1'b1;
            if (!stall && !ctl_write && ctl_t == ctl_lat - 1) begin
                mem_rd_data    = ctl_mem.exists(32'(ctl_addr)) ? ctl_mem[32'(ctl_addr)]
                                                               : default_word(ctl_addr);
                mem_data_valid = 1'b1;
            end
            if (!stall && ctl_t == ctl_lat) begin
                mem_busy       = 1'b0;
                ctl_active     = 0;
                busy_fall_time = $time;
                if (ctl_write) ctl_mem[32'(ctl_addr)] = ctl_wdata;
            end
        end
    end

    // Reference: flat word memory plus which word the one-entry cache holds.
    logic [15:0] ref_mem [int unsigned];
    bit          m_valid = 0;
    logic [21:0] m_tag = '0;

    function automatic logic [7:0] ref_byte(input logic [22:0] a);
        logic [15:0] w;
        w = ref_mem.exists(32'(a[22:1])) ? ref_mem[32'(a[22:1])] : default_word(a[22:1]);
        return a[0] ? w[7:0] : w[15:8];
    endfunction

    task automatic wait_ack(input bit is_ld, output bit ok);
        ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = is_ld ? ld_ack : rd_ack;
        end
    endtask

    task automatic do_read(input logic [22:0] a, output logic [7:0] data, output int lat,
                           output int ncmd, output time t_ack);
        int c0;
        bit got;
        c0 = cmd_cnt; rd_addr = a; rd_req = 1'b1; lat = 0; got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            got = rd_ack;
        end
        if (!got) check("rd_ack_wait", 32'(got), 1);
        data = rd_byte; ncmd = cmd_cnt - c0; t_ack = $time; rd_req = 1'b0;
        @(negedge clk);
        check("rd_ack_pulse", 32'(rd_ack), 0);
    endtask

    task automatic read_and_check(input logic [22:0] a, input string tag);
        logic [7:0] data, exp;
        int lat, ncmd;
        time t;
        bit exp_hit;
        exp_hit = m_valid && (m_tag == a[22:1]);
        exp = ref_byte(a);
        do_read(a, data, lat, ncmd, t);
        check({tag, "_data"}, 32'(data), 32'(exp));
        check({tag, "_cmds"}, 32'(ncmd), exp_hit ? 32'd0 : 32'd1);
        if (exp_hit) check({tag, "_lat"}, 32'(lat), 1);
        else begin
            check({tag, "_addr"}, 32'(last_addr), 32'(a[22:1]));
            check({tag, "_wr"}, 32'(last_write), 0);
        end
        check({tag, "_hold"}, 32'(rd_byte), 32'(exp));
        m_valid = 1;
        m_tag   = a[22:1];
    endtask

    task automatic do_load(input logic [21:0] a, input logic [15:0] d, input string tag);
        int c0;
        bit ok;
        c0 = cmd_cnt; ld_addr = a; ld_data = d; ld_req = 1'b1;
        wait_ack(1, ok);
        ld_req = 1'b0;
        ref_mem[32'(a)] = d;
        check({tag, "_ack"}, 32'(ok), 1);
        check({tag, "_cmds"}, 32'(cmd_cnt - c0), 1);
        check({tag, "_wr"}, 32'(last_write), 1);
        check({tag, "_addr"}, 32'(last_addr), 32'(a));
        check({tag, "_wdata"}, 32'(last_wdata), 32'(d));
        check({tag, "_lat"}, 32'($time - busy_fall_time), PER);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(ld_ack), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({rd_ack, ld_ack, mem_cmd_en, mem_cmd_write, timeout_err}), 0);
        check({tag, "_rd_byte"}, 32'(rd_byte), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_wr_data"}, 32'(mem_wr_data), 0);
    endtask

    logic [7:0] d1, d2, tdata;
    bit         ok1, ok2, okl, busy_seen;
    int         tlat, tcmd;
    time        tack;

    initial begin
        ctl_mem[32'h10] = 16'h1234;
        ref_mem[32'h10] = 16'h1234;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        read_and_check(23'h000020, "rd_miss");
        read_and_check(23'h000021, "rd_hit");
        do_load(22'h000010, 16'hA55A, "load1");
        read_and_check(23'h000020, "rd_wt1");
        do_load(22'h000010, 16'hBEEF, "load2");
        read_and_check(23'h000020, "rd_wt2");
        check("rd_wt2_const", 32'(rd_byte), 32'h0BE);

        // Simultaneous requests: read first, then the held load, then the next read.
        ack_q.delete();
        fork
            begin
                rd_addr = 23'h000200; rd_req = 1'b1;
                wait_ack(0, ok1);
                d1 = rd_byte;
                rd_addr = 23'h000403;
                wait_ack(0, ok2);
                d2 = rd_byte;
                rd_req = 1'b0;
            end
            begin
                ld_addr = 22'h000300; ld_data = 16'h0F1E; ld_req = 1'b1;
                wait_ack(1, okl);
                ld_req = 1'b0;
            end
        join
        ref_mem[32'h300] = 16'h0F1E;
        @(negedge clk);
        check("fair_acks", 32'({ok1, ok2, okl}), 32'h7);
        check("fair_count", 32'(ack_q.size()), 3);
        if (ack_q.size() >= 3) check("fair_order", 32'({ack_q[0][0], ack_q[1][0], ack_q[2][0]}), 32'b010);
        check("fair_d1", 32'(d1), 32'(ref_byte(23'h000200)));
        check("fair_d2", 32'(d2), 32'(ref_byte(23'h000403)));
        m_valid = 1; m_tag = 22'h000201;

        for (int i = 0; i < 60; i++) begin
            logic [21:0] w;
            w = 22'h000100 + 22'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) read_and_check({w, 1'($urandom)}, "rnd_rd");
            else do_load(w, 16'($urandom), "rnd_ld");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        stall = 1;
        do_read(23'h7FFFFE, tdata, tlat, tcmd, tack);
        check("tmo_data", 32'(tdata), 32'hFF);
        check("tmo_err", 32'(timeout_err), 1);
        check("tmo_cmds", 32'(tcmd), 1);
        check("tmo_lat", 32'(tack - issue_time), (TMO + 2) * PER);
        ctl_kill = 1;
        repeat (2) @(negedge clk);
        ctl_kill = 0; stall = 0; m_valid = 0;
        repeat (3) @(negedge clk);
        check("tmo_sticky", 32'(timeout_err), 1);
        read_and_check(23'h000200, "post_tmo");
        check("tmo_sticky2", 32'(timeout_err), 1);

        read_and_check(23'h000202, "pre_rst");
        rd_addr = 23'h000500; rd_req = 1'b1; busy_seen = 0;
        for (int n = 0; n < 50 && !busy_seen; n++) begin
            @(negedge clk);
            busy_seen = mem_busy;
        end
        check("rst_busy_wait", 32'(busy_seen), 1);
        @(negedge clk);
        reset_n = 1'b0; rd_req = 1'b0;
        #1 check_reset_outputs("mid_rst");
        ctl_kill = 1;
        repeat (2) @(negedge clk);
        ctl_kill = 0; reset_n = 1'b1; m_valid = 0;
        @(negedge clk);
        read_and_check(23'h000202, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
